// File: rtl/operand_bypass_stage.sv
`default_nettype none
// ============================================================================
//  Module      : operand_bypass_stage
//  Description : ID->EX operand stage. Holds the ID/EX operand register and a
//                DEPTH-entry history of in-flight writebacks, resolves source
//                operands by youngest-first forwarding, applies the A/B operand
//                selects, raises a one-cycle load-use stall and counts stalls.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock_i, reset_i        clock, synchronous active-high reset
//    flush_i                 kill ID instruction and EX register
//    id_valid_i/id_ready_o   ID handshake (ready drops on load-use hazard)
//    id_rs*_addr/used/data_i source register address, use flag, regfile data
//    id_pc_i, id_imm_i       PC and immediate
//    id_a_sel_i, id_b_sel_i  A: 0=rs1 1=pc   B: 0=rs2 1=imm
//    id_rd_addr_i/we_i       destination register / write enable
//    id_is_load_i            instruction is a load
//    ex_result_i             ALU result of the current EX instruction
//    mem_load_data_i         load data for the load held in history[0]
//    ex_*_o                  EX register contents
//    stall_cnt_o             saturating load-use stall counter
// ============================================================================
module operand_bypass_stage #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int DEPTH = 3
) (
    input  logic            clock_i,
    input  logic            reset_i,
    input  logic            flush_i,
    input  logic            id_valid_i,
    output logic            id_ready_o,
    input  logic [RA_W-1:0] id_rs1_addr_i,
    input  logic [RA_W-1:0] id_rs2_addr_i,
    input  logic            id_rs1_used_i,
    input  logic            id_rs2_used_i,
    input  logic [XLEN-1:0] id_rs1_data_i,
    input  logic [XLEN-1:0] id_rs2_data_i,
    input  logic [XLEN-1:0] id_pc_i,
    input  logic [XLEN-1:0] id_imm_i,
    input  logic            id_a_sel_i,
    input  logic            id_b_sel_i,
    input  logic [RA_W-1:0] id_rd_addr_i,
    input  logic            id_rd_we_i,
    input  logic            id_is_load_i,
    input  logic [XLEN-1:0] ex_result_i,
    input  logic [XLEN-1:0] mem_load_data_i,
    output logic            ex_valid_o,
    output logic [XLEN-1:0] ex_op_a_o,
    output logic [XLEN-1:0] ex_op_b_o,
    output logic [XLEN-1:0] ex_store_data_o,
    output logic [RA_W-1:0] ex_rd_addr_o,
    output logic            ex_rd_we_o,
    output logic            ex_is_load_o,
    output logic [31:0]     stall_cnt_o
);

    // ------------------------------------------------------------------
    // EX register
    // ------------------------------------------------------------------
    logic            ex_valid_q,      ex_valid_d;
    logic            ex_rd_we_q,      ex_rd_we_d;
    logic            ex_is_load_q,    ex_is_load_d;
    logic [RA_W-1:0] ex_rd_addr_q,    ex_rd_addr_d;
    logic [XLEN-1:0] ex_op_a_q,       ex_op_a_d;
    logic [XLEN-1:0] ex_op_b_q,       ex_op_b_d;
    logic [XLEN-1:0] ex_store_data_q, ex_store_data_d;

    // ------------------------------------------------------------------
    // Writeback history: entry 0 is the instruction that left EX last cycle
    // ------------------------------------------------------------------
    logic            hist_valid_q [DEPTH];
    logic            hist_we_q    [DEPTH];
    logic            hist_load_q  [DEPTH];
    logic [RA_W-1:0] hist_rd_q    [DEPTH];
    logic [XLEN-1:0] hist_data_q  [DEPTH];
    // Value each entry would forward; a load in entry 0 has its data arriving
    // from memory this cycle rather than in the stored field.
    logic [XLEN-1:0] hist_fwd_data [DEPTH];

    logic [31:0]     stall_cnt_q, stall_cnt_d;

    logic [XLEN-1:0] rs1_fwd, rs2_fwd;
    logic            hazard;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            hist_fwd_data[i] = hist_data_q[i];
        end
        if (hist_load_q[0]) begin
            hist_fwd_data[0] = mem_load_data_i;
        end
    end

    // Youngest-first forwarding: scan oldest to youngest so a younger match
    // overrides an older one, then force x0 to zero.
    always_comb begin
        rs1_fwd = id_rs1_data_i;
        rs2_fwd = id_rs2_data_i;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (hist_valid_q[i] && hist_we_q[i] && (hist_rd_q[i] == id_rs1_addr_i)) begin
                rs1_fwd = hist_fwd_data[i];
            end
            if (hist_valid_q[i] && hist_we_q[i] && (hist_rd_q[i] == id_rs2_addr_i)) begin
                rs2_fwd = hist_fwd_data[i];
            end
        end
        // A load in EX has no data yet; the hazard logic stalls that case.
        if (ex_valid_q && ex_rd_we_q && !ex_is_load_q && (ex_rd_addr_q == id_rs1_addr_i)) begin
            rs1_fwd = ex_result_i;
        end
        if (ex_valid_q && ex_rd_we_q && !ex_is_load_q && (ex_rd_addr_q == id_rs2_addr_i)) begin
            rs2_fwd = ex_result_i;
        end
        if (id_rs1_addr_i == '0) begin
            rs1_fwd = '0;
        end
        if (id_rs2_addr_i == '0) begin
            rs2_fwd = '0;
        end
    end

    always_comb begin
        hazard = id_valid_i && !flush_i && ex_valid_q && ex_is_load_q && ex_rd_we_q
                 && (ex_rd_addr_q != '0)
                 && ((id_rs1_used_i && (id_rs1_addr_i == ex_rd_addr_q))
                  || (id_rs2_used_i && (id_rs2_addr_i == ex_rd_addr_q)));
    end

    assign id_ready_o = !hazard;

    // EX register next state: bubbles clear control bits, operands hold.
    always_comb begin
        ex_valid_d      = 1'b0;
        ex_rd_we_d      = 1'b0;
        ex_is_load_d    = 1'b0;
        ex_rd_addr_d    = ex_rd_addr_q;
        ex_op_a_d       = ex_op_a_q;
        ex_op_b_d       = ex_op_b_q;
        ex_store_data_d = ex_store_data_q;
        if (!flush_i && !hazard && id_valid_i) begin
            ex_valid_d      = 1'b1;
            ex_rd_we_d      = id_rd_we_i;
            ex_is_load_d    = id_is_load_i;
            ex_rd_addr_d    = id_rd_addr_i;
            ex_op_a_d       = id_a_sel_i ? id_pc_i  : rs1_fwd;
            ex_op_b_d       = id_b_sel_i ? id_imm_i : rs2_fwd;
            ex_store_data_d = rs2_fwd;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hazard && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            ex_valid_q      <= 1'b0;
            ex_rd_we_q      <= 1'b0;
            ex_is_load_q    <= 1'b0;
            ex_rd_addr_q    <= '0;
            ex_op_a_q       <= '0;
            ex_op_b_q       <= '0;
            ex_store_data_q <= '0;
            stall_cnt_q     <= '0;
        end else begin
            ex_valid_q      <= ex_valid_d;
            ex_rd_we_q      <= ex_rd_we_d;
            ex_is_load_q    <= ex_is_load_d;
            ex_rd_addr_q    <= ex_rd_addr_d;
            ex_op_a_q       <= ex_op_a_d;
            ex_op_b_q       <= ex_op_b_d;
            ex_store_data_q <= ex_store_data_d;
            stall_cnt_q     <= stall_cnt_d;
        end
    end

    // History entry 0 takes the EX register unconditionally; flush does not
    // clear history since older instructions are already committed.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            hist_valid_q[0] <= 1'b0;
            hist_we_q[0]    <= 1'b0;
            hist_load_q[0]  <= 1'b0;
            hist_rd_q[0]    <= '0;
            hist_data_q[0]  <= '0;
        end else begin
            hist_valid_q[0] <= ex_valid_q;
            hist_we_q[0]    <= ex_rd_we_q;
            hist_load_q[0]  <= ex_is_load_q;
            hist_rd_q[0]    <= ex_rd_addr_q;
            hist_data_q[0]  <= ex_result_i;
        end
    end

    // Older entries shift down; entry 1 captures the resolved load data.
    for (genvar g = 1; g < DEPTH; g++) begin : g_hist
        always_ff @(posedge clock_i) begin
            if (reset_i) begin
                hist_valid_q[g] <= 1'b0;
                hist_we_q[g]    <= 1'b0;
                hist_load_q[g]  <= 1'b0;
                hist_rd_q[g]    <= '0;
                hist_data_q[g]  <= '0;
            end else begin
                hist_valid_q[g] <= hist_valid_q[g-1];
                hist_we_q[g]    <= hist_we_q[g-1];
                hist_load_q[g]  <= hist_load_q[g-1];
                hist_rd_q[g]    <= hist_rd_q[g-1];
                hist_data_q[g]  <= hist_fwd_data[g-1];
            end
        end
    end

    assign ex_valid_o      = ex_valid_q;
    assign ex_op_a_o       = ex_op_a_q;
    assign ex_op_b_o       = ex_op_b_q;
    assign ex_store_data_o = ex_store_data_q;
    assign ex_rd_addr_o    = ex_rd_addr_q;
    assign ex_rd_we_o      = ex_rd_we_q;
    assign ex_is_load_o    = ex_is_load_q;
    assign stall_cnt_o     = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_operand_bypass_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_operand_bypass_stage
//  Description : Scoreboard bench for operand_bypass_stage. Directed
//                instructions push their hand-computed EX contents into a
//                queue; a negedge monitor pops and compares whenever
//                ex_valid is high. Stall/bubble/reset effects are checked
//                directly by the stimulus process.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_operand_bypass_stage;

    logic        clock = 1'b0;
    logic        reset, flush, id_valid, id_ready;
    logic [4:0]  rs1_a, rs2_a, rd_a;
    logic        rs1_u, rs2_u, a_sel, b_sel, rd_we, is_load;
    logic [31:0] rs1_d, rs2_d, pc, imm, ex_result, mem_data;
    logic        ex_valid, ex_rd_we, ex_is_load;
    logic [31:0] op_a, op_b, st_data, stall_cnt;
    logic [4:0]  ex_rd;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] s;
        logic [4:0]  rd;
        logic        we;
        logic        ld;
    } exp_t;

    exp_t q[$];

    operand_bypass_stage #(.XLEN(32), .RA_W(5), .DEPTH(3)) dut (
        .clock_i(clock), .reset_i(reset), .flush_i(flush),
        .id_valid_i(id_valid), .id_ready_o(id_ready),
        .id_rs1_addr_i(rs1_a), .id_rs2_addr_i(rs2_a),
        .id_rs1_used_i(rs1_u), .id_rs2_used_i(rs2_u),
        .id_rs1_data_i(rs1_d), .id_rs2_data_i(rs2_d),
        .id_pc_i(pc), .id_imm_i(imm),
        .id_a_sel_i(a_sel), .id_b_sel_i(b_sel),
        .id_rd_addr_i(rd_a), .id_rd_we_i(rd_we), .id_is_load_i(is_load),
        .ex_result_i(ex_result), .mem_load_data_i(mem_data),
        .ex_valid_o(ex_valid), .ex_op_a_o(op_a), .ex_op_b_o(op_b),
        .ex_store_data_o(st_data), .ex_rd_addr_o(ex_rd),
        .ex_rd_we_o(ex_rd_we), .ex_is_load_o(ex_is_load),
        .stall_cnt_o(stall_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [31:0] s,
                        input logic [4:0] rd, input logic we, input logic ld);
        exp_t e;
        e.a = a; e.b = b; e.s = s; e.rd = rd; e.we = we; e.ld = ld;
        q.push_back(e);
    endtask

    task automatic clr();
        flush = 0; id_valid = 0;
        rs1_a = 0; rs2_a = 0; rs1_u = 0; rs2_u = 0; rs1_d = 0; rs2_d = 0;
        pc = 0; imm = 0; a_sel = 0; b_sel = 0; rd_a = 0; rd_we = 0; is_load = 0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Monitor: every valid EX presentation must match the oldest expectation.
    always @(negedge clock) begin
        if (ex_valid === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ex: ex_valid=1 with no expected entry at %0t", $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("ex_op_a", op_a, e.a);
                chk("ex_op_b", op_b, e.b);
                chk("ex_store_data", st_data, e.s);
                chk("ex_rd_addr", {27'd0, ex_rd}, {27'd0, e.rd});
                chk("ex_rd_we", {31'd0, ex_rd_we}, {31'd0, e.we});
                chk("ex_is_load", {31'd0, ex_is_load}, {31'd0, e.ld});
            end
        end
    end

    initial begin
        reset = 1; clr(); ex_result = 0; mem_data = 0;
        repeat (2) @(posedge clock);
        #1;
        reset = 0;
        #1;
        chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_op_a", op_a, 32'd0);
        chk("rst_op_b", op_b, 32'd0);
        chk("rst_store", st_data, 32'd0);
        chk("rst_rd", {27'd0, ex_rd}, 32'd0);
        chk("rst_we_ld", {30'd0, ex_rd_we, ex_is_load}, 32'd0);
        chk("rst_stall_cnt", stall_cnt, 32'd0);
        chk("rst_id_ready", {31'd0, id_ready}, 32'd1);

        // T1: addi x1, x0, 5 (regfile garbage on x0 must read as 0)
        clr(); id_valid = 1; rs1_a = 0; rs1_u = 1; rs1_d = 32'h1234;
        b_sel = 1; imm = 5; rd_a = 1; rd_we = 1;
        push(32'd0, 32'd5, 32'd0, 5'd1, 1, 0);
        step();
        chk("t1_stall_cnt", stall_cnt, 32'd0);

        // T2: write x3 (pc/imm operands); EX (x1) result 6
        clr(); id_valid = 1; a_sel = 1; pc = 32'h100; b_sel = 1; imm = 32'h20;
        rd_a = 3; rd_we = 1; ex_result = 32'h6;
        push(32'h100, 32'h20, 32'd0, 5'd3, 1, 0);
        step();

        // T3: EX holds x3 = 0x10; read x3 with regfile 0xDEAD
        clr(); id_valid = 1; rs1_a = 3; rs1_u = 1; rs1_d = 32'hDEAD;
        b_sel = 1; imm = 1; rd_a = 7; rd_we = 1; ex_result = 32'h10;
        push(32'h10, 32'h1, 32'd0, 5'd7, 1, 0);
        step();

        // T4: first write of x4 (0x11)
        clr(); id_valid = 1; a_sel = 1; pc = 0; b_sel = 1; imm = 32'h11;
        rd_a = 4; rd_we = 1; ex_result = 32'h77;
        push(32'h0, 32'h11, 32'd0, 5'd4, 1, 0);
        step();

        // T5: write x9; EX (x4) result 0x11
        clr(); id_valid = 1; a_sel = 1; pc = 32'h200; b_sel = 1; imm = 32'h3;
        rd_a = 9; rd_we = 1; ex_result = 32'h11;
        push(32'h200, 32'h3, 32'd0, 5'd9, 1, 0);
        step();

        // T6: second write of x4; EX (x9) result 0x99
        clr(); id_valid = 1; a_sel = 1; pc = 32'h300; b_sel = 1; imm = 32'h4;
        rd_a = 4; rd_we = 1; ex_result = 32'h99;
        push(32'h300, 32'h4, 32'd0, 5'd4, 1, 0);
        step();

        // T7: EX writes x4=0x22, history[1] holds x4=0x11 -> 0x22 on both ports
        clr(); id_valid = 1; rs1_a = 4; rs2_a = 4; rs1_u = 1; rs2_u = 1;
        rs1_d = 32'hBAD; rs2_d = 32'hBAD; rd_a = 10; rd_we = 1; ex_result = 32'h22;
        push(32'h22, 32'h22, 32'h22, 5'd10, 1, 0);
        step();

        // T8: x4=0x22 now in history[0], 0x11 in history[2]; rd_we = 0
        clr(); id_valid = 1; rs1_a = 4; rs1_u = 1; rs1_d = 32'hBAD;
        b_sel = 1; imm = 0; rd_a = 11; rd_we = 0; ex_result = 32'h55;
        push(32'h22, 32'h0, 32'd0, 5'd11, 0, 0);
        step();

        // T9: EX targets x11 with we=0 -> must not forward
        clr(); id_valid = 1; rs1_a = 11; rs1_u = 1; rs1_d = 32'h1111;
        b_sel = 1; imm = 0; ex_result = 32'h66;
        push(32'h1111, 32'h0, 32'd0, 5'd0, 0, 0);
        step();

        // T10: lw x5
        clr(); id_valid = 1; a_sel = 1; pc = 32'h400; b_sel = 1; imm = 8;
        rd_a = 5; rd_we = 1; is_load = 1; ex_result = 32'h0;
        push(32'h400, 32'h8, 32'd0, 5'd5, 1, 1);
        step();

        // T11: consumer of x5 on rs2 -> load-use hazard
        clr(); id_valid = 1; rs2_a = 5; rs2_u = 1; rs2_d = 32'hBEEF;
        rd_a = 12; rd_we = 1; ex_result = 32'h408;
        #1;
        chk("lu_id_ready", {31'd0, id_ready}, 32'd0);
        step();
        chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
        chk("lu_stall_cnt", stall_cnt, 32'd1);

        // T12: same instruction re-presented; load data from memory forwarded
        mem_data = 32'hCAFE; ex_result = 32'h0;
        #1;
        chk("lu_ready_again", {31'd0, id_ready}, 32'd1);
        push(32'h0, 32'hCAFE, 32'hCAFE, 5'd12, 1, 0);
        step();
        chk("lu_stall_once", stall_cnt, 32'd1);

        // T13: load data now captured in history[1]; this instr is lw x13
        clr(); id_valid = 1; rs1_a = 5; rs1_u = 1; rs1_d = 32'h5555;
        b_sel = 1; imm = 4; rd_a = 13; rd_we = 1; is_load = 1;
        mem_data = 32'h1; ex_result = 32'h77;
        push(32'hCAFE, 32'h4, 32'd0, 5'd13, 1, 1);
        step();

        // T14: load-use on x13 with simultaneous flush -> flush wins
        clr(); id_valid = 1; rs1_a = 13; rs1_u = 1; flush = 1; rd_a = 15; rd_we = 1;
        #1;
        chk("flush_id_ready", {31'd0, id_ready}, 32'd1);
        step();
        chk("flush_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("flush_stall_cnt", stall_cnt, 32'd1);

        // T15: write x0
        clr(); id_valid = 1; a_sel = 1; pc = 0; b_sel = 1; imm = 32'h99; rd_a = 0; rd_we = 1;
        push(32'h0, 32'h99, 32'd0, 5'd0, 1, 0);
        step();

        // T16: EX writes x0=0x99; read x0 -> 0. Instr is lw x14
        clr(); id_valid = 1; rs1_a = 0; rs1_u = 1; rs1_d = 32'h5;
        b_sel = 1; imm = 1; rd_a = 14; rd_we = 1; is_load = 1; ex_result = 32'h99;
        push(32'h0, 32'h1, 32'd0, 5'd14, 1, 1);
        step();

        // T17: load-use on x14 while reset is asserted -> reset wins
        clr(); id_valid = 1; rs1_a = 14; rs1_u = 1; rd_a = 16; rd_we = 1; ex_result = 32'h0;
        #1;
        chk("stall_seen", {31'd0, id_ready}, 32'd0);
        reset = 1;
        step();
        chk("rst2_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst2_op_a", op_a, 32'd0);
        chk("rst2_op_b", op_b, 32'd0);
        chk("rst2_store", st_data, 32'd0);
        chk("rst2_rd_we_ld", {25'd0, ex_rd, ex_rd_we, ex_is_load}, 32'd0);
        chk("rst2_stall_cnt", stall_cnt, 32'd0);

        reset = 0; clr();
        repeat (3) step();
        chk("queue_drained", q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/operand_bypass_stage.md
# operand_bypass_stage

Parametrised ID→EX operand stage for the pipelined core. It owns the ID/EX operand register and a DEPTH-entry history of in-flight writebacks. When an instruction is accepted, it resolves each source operand by youngest-first forwarding and applies the A/B operand selects. It raises a one-cycle load-use stall and counts stalls for performance reporting.

## Interface
Parameters:
- XLEN, 32, datapath width
- RA_W, 5, register address width
- DEPTH, 3, number of post-EX history entries tracked until the regfile write is visible (min 2)

Ports:
- clock  in  1  pipeline clock
- reset  in  1  synchronous, active-high
- flush  in  1  kill ID instruction and EX register (redirect)
- id_valid  in  1  ID presents an instruction
- id_ready  out  1  instruction accepted this cycle
- id_rs1_addr, id_rs2_addr  in  RA_W  source registers
- id_rs1_used, id_rs2_used  in  1  source actually read
- id_rs1_data, id_rs2_data  in  XLEN  regfile read data
- id_pc, id_imm  in  XLEN  PC and immediate
- id_a_sel  in  1  0 = rs1, 1 = pc
- id_b_sel  in  1  0 = rs2, 1 = imm
- id_rd_addr  in  RA_W  destination register
- id_rd_we  in  1  writes rd
- id_is_load  in  1  load instruction
- ex_result  in  XLEN  ALU result of the current EX instruction (combinational, same cycle)
- mem_load_data  in  XLEN  load data for the load held in history[0]
- ex_valid  out  1  EX register valid
- ex_op_a, ex_op_b  out  XLEN  ALU operands
- ex_store_data  out  XLEN  forwarded rs2 (store data)
- ex_rd_addr  out  RA_W  destination register of the EX instruction
- ex_rd_we  out  1  EX instruction writes rd
- ex_is_load  out  1  EX instruction is a load
- stall_cnt  out  32  saturating load-use stall counter

## Operation
- History entry fields: valid, rd, we, is_load, data.
- Every cycle, the history shifts unconditionally:
  - EX register → history[0]; data = ex_result.
  - history[0] → history[1]; data = mem_load_data if is_load, else the stored data.
  - history[i] → history[i+1] for i ≥ 1; history[DEPTH-1] is dropped.
- Forwarding candidates, youngest first:
  1. EX register: data = ex_result, only if not a load.
  2. history[0]: data = mem_load_data if is_load, else the stored data.
  3. history[1..DEPTH-1]: stored data.
  4. Regfile read data.
- A candidate matches only if valid & we & rd == source address & source address != 0. Address 0 always yields 0.
- Operand A = id_pc if id_a_sel, else forwarded rs1. Operand B = id_imm if id_b_sel, else forwarded rs2. ex_store_data = forwarded rs2, always.
- Hazard = id_valid & !flush & EX valid & ex_is_load & ex_rd_we & ex_rd_addr != 0 & ((id_rs1_used & rs1 match) | (id_rs2_used & rs2 match)).
- id_ready = !hazard (combinational).
- EX register update each cycle, in priority order:
  - flush: bubble.
  - hazard: bubble; the ID instruction is held upstream.
  - id_valid: load the resolved operands and control.
  - otherwise: bubble.
- A bubble clears ex_valid, ex_rd_we and ex_is_load. Operand fields are don't-care and are held.
- stall_cnt increments on each hazard cycle and saturates at 0xFFFFFFFF.
- flush does not clear the history (older instructions are committed).

## Timing
- Reset, synchronous: all history valids 0; ex_valid, ex_rd_we, ex_is_load = 0; ex_op_a, ex_op_b, ex_store_data = 0; ex_rd_addr = 0; stall_cnt = 0. id_ready = 1 after reset.
- Latency: accepted instruction appears on ex_* the next cycle. A load-use dependent appears 2 cycles after first presentation (1 bubble).
- Hazard lasts exactly one cycle. Next cycle the load is in history[0] and mem_load_data is forwarded.
- Simultaneous flush and hazard: flush wins; id_ready = 1, no stall counted.
- Reset asserted mid-stall: reset wins; all state cleared, no count.
- Multiple matches: the youngest entry wins, even if an older entry is a load.
- An entry with we = 0 never forwards, even on address match.

## Test plan
- After reset, ID: addi x1 (rs1 = x0, a_sel = 0, b_sel = 1, imm = 5) → next cycle ex_valid = 1, op_a = 0, op_b = 5, stall_cnt = 0.
- EX: x3 = ALU result 0x10. ID: rs1 = x3 with regfile value 0xDEAD → op_a = 0x10 (EX forward wins).
- Back-to-back writes to x4: EX writes 0x22, history[1] holds 0x11. ID reads x4 → 0x22. Next cycle, with no new write, → 0x22 from history[0].
- EX: lw x5. ID uses x5 as rs2 → id_ready = 0 for 1 cycle, bubble issued, stall_cnt = 1. Next cycle, with mem_load_data = 0xCAFE → op_b = 0xCAFE, ex_store_data = 0xCAFE.
- Load-use hazard with flush = 1 the same cycle → id_ready = 1, ex_valid = 0 next cycle, stall_cnt unchanged.
- EX: write to x0 = 0x99 and rs1 = x0 → op_a = 0. Reset asserted during a stall → all ex_* = 0 and stall_cnt = 0 next cycle.
